// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one 1-bit full adder plus a carry flop, fed LSB-first
// over N cycles, with a start/busy/done handshake around the result registers.

module fulladder (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Co,
  output logic S
);
  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Co
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  sreg;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_co;

  // The single shared adder cell always looks at the current LSBs and carry.
  fulladder u_fa (
    .A  (op_a[0]),
    .B  (op_b[0]),
    .Ci (carry),
    .Co (fa_co),
    .S  (fa_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Co    <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= A;
            op_b  <= B;
            carry <= Ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_co;
          sreg  <= {fa_s, sreg[N-1:1]};
          cnt   <= cnt + 1'b1;
          // Last bit: publish the result straight from the adder so S/Co stay
          // untouched for the whole SHIFT phase.
          if (cnt == LAST) begin
            S     <= {fa_s, sreg[N-1:1]};
            Co    <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
